// File: rtl/interrupt_controller.sv
// AVR interrupt entry/exit sequencer: pushes the return PC, loads the vector,
// and on RETI pops the PC back and re-enables interrupts.
module interrupt_controller #(
    parameter logic [13:0] VECTOR_BASE = 14'h008,
    parameter int          VECTOR_STEP = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  tifr,
    input  logic [7:0]  timsk,
    input  logic        sreg_i,
    input  logic        instr_done,
    input  logic        reti,
    input  logic [13:0] program_counter,
    input  logic [15:0] sp,
    input  logic [7:0]  mem_rdata,
    output logic        hold,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic        sp_we,
    output logic [15:0] sp_new,
    output logic        pc_overwrite,
    output logic [13:0] pc_new,
    output logic        sreg_i_clr,
    output logic        sreg_i_set,
    output logic [7:0]  tifr_clr,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH_L,
        S_PUSH_H,
        S_VECTOR,
        S_POP_H,
        S_POP_L,
        S_RET
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [13:0] r_pc;
    logic [15:0] r_sp;
    logic [2:0]  r_idx;
    logic [5:0]  r_pc_hi;
    logic        r_armed;

    logic [7:0]  w_pending;
    logic [2:0]  w_idx;
    logic        w_reti;
    logic        w_enter;
    logic [13:0] w_vector;

    assign w_pending = tifr & timsk;

    // Later iterations win, so the highest set bit is selected
    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_pending[i]) w_idx = 3'(i);
        end
    end

    assign w_reti   = instr_done & reti;
    assign w_enter  = instr_done & ~reti & r_armed & sreg_i & (|w_pending);
    assign w_vector = VECTOR_BASE
                    + 14'(VECTOR_STEP) * (14'd7 - {11'd0, r_idx});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc    <= '0;
            r_sp    <= '0;
            r_idx   <= '0;
            r_pc_hi <= '0;
            r_armed <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_enter) begin
                        r_pc  <= program_counter;
                        r_sp  <= sp;
                        r_idx <= w_idx;
                    end
                    if (instr_done && !reti && !r_armed) r_armed <= 1'b1;
                end
                S_POP_H: r_sp    <= sp;
                S_POP_L: r_pc_hi <= mem_rdata[5:0];
                S_RET:   r_armed <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next       = r_state;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        sp_we        = 1'b0;
        sp_new       = '0;
        pc_overwrite = 1'b0;
        pc_new       = '0;
        sreg_i_clr   = 1'b0;
        sreg_i_set   = 1'b0;
        tifr_clr     = '0;
        hold         = (r_state != S_IDLE);
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_reti)       w_next = S_POP_H;
                else if (w_enter) w_next = S_PUSH_L;
            end
            S_PUSH_L: begin
                mem_addr  = r_sp;
                mem_wdata = r_pc[7:0];
                mem_we    = 1'b1;
                w_next    = S_PUSH_H;
            end
            S_PUSH_H: begin
                mem_addr  = r_sp - 16'd1;
                mem_wdata = {2'b00, r_pc[13:8]};
                mem_we    = 1'b1;
                sp_we     = 1'b1;
                sp_new    = r_sp - 16'd2;
                w_next    = S_VECTOR;
            end
            S_VECTOR: begin
                pc_overwrite = 1'b1;
                pc_new       = w_vector;
                sreg_i_clr   = 1'b1;
                tifr_clr     = 8'd1 << r_idx;
                w_next       = S_IDLE;
            end
            S_POP_H: begin
                mem_addr = sp + 16'd1;
                mem_re   = 1'b1;
                w_next   = S_POP_L;
            end
            S_POP_L: begin
                mem_addr = r_sp + 16'd2;
                mem_re   = 1'b1;
                w_next   = S_RET;
            end
            S_RET: begin
                pc_overwrite = 1'b1;
                pc_new       = {r_pc_hi, mem_rdata};
                sp_we        = 1'b1;
                sp_new       = r_sp + 16'd2;
                sreg_i_set   = 1'b1;
                w_next       = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: expected strobe cycles are queued
// by the stimulus and popped by a negedge monitor.
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  tifr = '0;
    logic [7:0]  timsk = '0;
    logic        sreg_i = 1'b0;
    logic        instr_done = 1'b0;
    logic        reti = 1'b0;
    logic [13:0] program_counter = '0;
    logic [15:0] sp = '0;
    logic [7:0]  mem_rdata = '0;
    logic        hold;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic        sp_we;
    logic [15:0] sp_new;
    logic        pc_overwrite;
    logic [13:0] pc_new;
    logic        sreg_i_clr;
    logic        sreg_i_set;
    logic [7:0]  tifr_clr;
    logic        busy;

    typedef struct packed {
        logic        we;
        logic        re;
        logic        spwe;
        logic        pcow;
        logic        iclr;
        logic        iset;
        logic [7:0]  tclr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [15:0] spn;
        logic [13:0] pcn;
    } obs_t;

    obs_t       exp_q[$];
    obs_t       o;
    obs_t       e;
    logic [7:0] mem [0:65535];
    logic       chk_idle = 1'b0;
    logic       chk_end = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;

    interrupt_controller dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .tifr            (tifr),
        .timsk           (timsk),
        .sreg_i          (sreg_i),
        .instr_done      (instr_done),
        .reti            (reti),
        .program_counter (program_counter),
        .sp              (sp),
        .mem_rdata       (mem_rdata),
        .hold            (hold),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_we          (mem_we),
        .mem_re          (mem_re),
        .sp_we           (sp_we),
        .sp_new          (sp_new),
        .pc_overwrite    (pc_overwrite),
        .pc_new          (pc_new),
        .sreg_i_clr      (sreg_i_clr),
        .sreg_i_set      (sreg_i_set),
        .tifr_clr        (tifr_clr),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Data-space model: read data appears one cycle after mem_re
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        o = '{we: mem_we, re: mem_re, spwe: sp_we, pcow: pc_overwrite,
              iclr: sreg_i_clr, iset: sreg_i_set, tclr: tifr_clr,
              addr: mem_addr, wdata: mem_wdata, spn: sp_new, pcn: pc_new};
        if (o.we | o.re | o.spwe | o.pcow | o.iclr | o.iset | (|o.tclr)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_strobe got=%h want=none", o);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL seq got=%h want=%h", o, e);
                end
            end
        end
        if (chk_idle) begin
            n_cmp++;
            if ({hold, busy, o} !== '0) begin
                n_err++;
                $display("FAIL idle got=%h want=0", {hold, busy, o});
            end
        end
        if (chk_end) begin
            n_cmp++;
            if (exp_q.size() != 0) begin
                n_err++;
                $display("FAIL leftover got=%0d want=0", exp_q.size());
            end
        end
    end

    task automatic exp_entry(input logic [15:0] s, input logic [13:0] p,
                             input logic [13:0] vec, input logic [7:0] clr);
        obs_t x;
        x = '0; x.we = 1'b1; x.addr = s; x.wdata = p[7:0];
        exp_q.push_back(x);
        x = '0; x.we = 1'b1; x.addr = s - 16'd1; x.wdata = {2'b00, p[13:8]};
        x.spwe = 1'b1; x.spn = s - 16'd2;
        exp_q.push_back(x);
        x = '0; x.pcow = 1'b1; x.pcn = vec; x.iclr = 1'b1; x.tclr = clr;
        exp_q.push_back(x);
    endtask

    task automatic exp_reti(input logic [15:0] s, input logic [13:0] p);
        obs_t x;
        x = '0; x.re = 1'b1; x.addr = s + 16'd1;
        exp_q.push_back(x);
        x = '0; x.re = 1'b1; x.addr = s + 16'd2;
        exp_q.push_back(x);
        x = '0; x.pcow = 1'b1; x.pcn = p; x.spwe = 1'b1;
        x.spn = s + 16'd2; x.iset = 1'b1;
        exp_q.push_back(x);
    endtask

    task automatic check_idle();
        chk_idle = 1'b1;
        @(negedge clk);
        #1 chk_idle = 1'b0;
    endtask

    task automatic boundary(input logic r, input logic chk);
        @(posedge clk);
        #1 instr_done = 1'b1; reti = r;
        @(posedge clk);
        #1 instr_done = 1'b0; reti = 1'b0;
        if (chk) check_idle();
        repeat (4) @(posedge clk);
    endtask

    initial begin
        check_idle();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        check_idle();

        // T1: lowest-priority vector
        sp = 16'h085F; program_counter = 14'h0123;
        tifr = 8'h01; timsk = 8'h01; sreg_i = 1'b1;
        exp_entry(16'h085F, 14'h0123, 14'h016, 8'h01);
        boundary(1'b0, 1'b0);
        tifr = 8'h00;

        // T2: priority, then remaining flag
        sp = 16'h0900; program_counter = 14'h0456;
        tifr = 8'h12; timsk = 8'h12;
        exp_entry(16'h0900, 14'h0456, 14'h00E, 8'h10);
        boundary(1'b0, 1'b0);
        tifr = 8'h02;
        exp_entry(16'h0900, 14'h0456, 14'h014, 8'h02);
        boundary(1'b0, 1'b0);
        tifr = 8'h00;

        // T3: blocked by I=0, then by timsk=0
        tifr = 8'hFF; timsk = 8'hFF; sreg_i = 1'b0;
        for (int i = 0; i < 10; i++) boundary(1'b0, 1'b1);
        sreg_i = 1'b1; timsk = 8'h00;
        for (int i = 0; i < 10; i++) boundary(1'b0, 1'b1);
        tifr = 8'h00;

        // T4: RETI from T1's frame; pending IRQ waits one instruction
        sp = 16'h085D; program_counter = 14'h0300;
        tifr = 8'h01; timsk = 8'h01;
        exp_reti(16'h085D, 14'h0123);
        boundary(1'b1, 1'b0);
        boundary(1'b0, 1'b1);
        sp = 16'h085F;
        exp_entry(16'h085F, 14'h0300, 14'h016, 8'h01);
        boundary(1'b0, 1'b0);
        tifr = 8'h00;

        // T5: SP wraparound on push and pop, reti beats pending
        sp = 16'h0000; program_counter = 14'h3ABC; tifr = 8'h01;
        exp_entry(16'h0000, 14'h3ABC, 14'h016, 8'h01);
        boundary(1'b0, 1'b0);
        sp = 16'hFFFE;
        exp_reti(16'hFFFE, 14'h3ABC);
        boundary(1'b1, 1'b0);
        tifr = 8'h00;
        boundary(1'b0, 1'b1);

        // T6: reset during PUSH_H
        sp = 16'h085F; program_counter = 14'h0155;
        tifr = 8'h80; timsk = 8'h80;
        e = '0; e.we = 1'b1; e.addr = 16'h085F; e.wdata = 8'h55;
        exp_q.push_back(e);
        @(posedge clk);
        #1 instr_done = 1'b1;
        @(posedge clk);
        #1 instr_done = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b0;
        check_idle();
        tifr = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) check_idle();
        repeat (6) @(posedge clk);

        chk_end = 1'b1;
        @(negedge clk);
        #1 chk_end = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
